// File: rtl/xpmwrap_fifo_reader.sv
// xpmwrap_fifo_reader
// Read-side companion for a standard-mode (non-FWFT) synchronous FIFO. It issues
// fifo_rd_en and captures fifo_dout one cycle later into a 2-entry buffer. The
// buffer is presented as a valid/ready stream master, so full throughput is kept
// under arbitrary backpressure.
// Optional beat counter: define XPMWRAP_FIFO_READER_BEAT_COUNT_EN to build beat_count.
// Without it, beat_count is tied to zero.
module xpmwrap_fifo_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   wr_clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  input  logic                   fifo_rd_rst_busy,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] beat_count
);

  // A read was issued last cycle, so its word is on fifo_dout this cycle.
  logic       inflight_q, inflight_d;
  // Number of words held in the buffer (0..2).
  logic [1:0] occ_q, occ_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       pop;
  // Occupancy plus in-flight, less this cycle's pop.
  // This is also the next occupancy before any new read.
  logic [1:0] level_after_pop;

  logic [DATA_WIDTH-1:0] entry [2];

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = entry[rd_ptr_q];
  assign pop     = m_valid & m_ready;

  // Issue decision and next-state.
  // A new read is allowed only if its word will have a free slot when it lands.
  always_comb begin
    level_after_pop = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    fifo_rd_en      = rst_n & ~fifo_empty & ~fifo_rd_rst_busy & (level_after_pop <= 2'd1);
    occ_d           = level_after_pop;
    inflight_d      = fifo_rd_en;
    wr_ptr_d        = wr_ptr_q ^ inflight_q;
    rd_ptr_d        = rd_ptr_q ^ pop;
  end

  // Control state register.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer entries: capture the in-flight word at the write pointer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] entry_q;

    // Per-entry storage; cleared by reset so m_data reads zero after reset.
    always_ff @(posedge wr_clk) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else if (inflight_q && (wr_ptr_q == 1'(gi))) begin
        entry_q <= fifo_dout;
      end
    end

    assign entry[gi] = entry_q;
  end

`ifdef XPMWRAP_FIFO_READER_BEAT_COUNT_EN
  logic [COUNT_WIDTH-1:0] beat_count_q;

  // Count accepted beats. The counter wraps naturally and only reset clears it.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      beat_count_q <= '0;
    end else if (pop) begin
      beat_count_q <= beat_count_q + 1'b1;
    end
  end

  assign beat_count = beat_count_q;
`else
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_xpmwrap_fifo_reader.sv
// Bench for xpmwrap_fifo_reader.
// It models the standard-mode FIFO with a queue. It also keeps a scoreboard of
// words that have been read but not yet accepted. Every cycle it predicts
// fifo_rd_en, m_valid, m_data and beat_count from that scoreboard.
module tb_xpmwrap_fifo_reader;

  logic        wr_clk;
  logic        rst_n;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_rst_busy;
  logic        fifo_rd_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] beat_count;

  xpmwrap_fifo_reader #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
    .wr_clk           (wr_clk),
    .rst_n            (rst_n),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_rd_rst_busy (fifo_rd_rst_busy),
    .fifo_rd_en       (fifo_rd_en),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .beat_count       (beat_count)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int checks   = 0;
  int failures = 0;

  // FIFO contents and scoreboard of words read but not yet accepted downstream.
  logic [31:0] fifo_q [$];
  logic [31:0] exp_q  [$];
  int unsigned exp_beats   = 0;
  bit          last_rd     = 1'b0;
  bit          after_reset = 1'b0;
  bit          stall_prev  = 1'b0;
  logic [31:0] prev_d      = '0;
  int          cyc         = 0;

  // Values sampled in the most recent cycle.
  logic        s_rd, s_v, s_pop;
  logic [31:0] s_d, s_bc;

  typedef struct packed {
    logic rst;
    logic rdy;
    logic busy;
    logic exp_rd;
    logic exp_v;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_bc();
`ifdef XPMWRAP_FIFO_READER_BEAT_COUNT_EN
    return 32'(exp_beats);
`else
    return 32'd0;
`endif
  endfunction

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // One clock cycle.
  // Inputs are applied now (just after a rising edge) and outputs are checked at
  // the falling edge. The FIFO model and scoreboard advance after the next rising edge.
  task automatic cycle(input logic rst_v, input logic rdy_v, input logic busy_v);
    int          outstanding;
    logic        exp_v, exp_rd;
    logic [31:0] w;
    rst_n = rst_v;
    m_ready = rdy_v;
    fifo_rd_rst_busy = busy_v;
    @(negedge wr_clk);
    s_rd  = fifo_rd_en;
    s_v   = m_valid;
    s_d   = m_data;
    s_pop = m_valid & m_ready;
    s_bc  = beat_count;
    outstanding = exp_q.size();
    exp_v  = (outstanding - int'(last_rd)) > 0;
    exp_rd = rst_v && !fifo_empty && !busy_v && ((outstanding - int'(exp_v && rdy_v)) <= 1);
    chk("m_valid", s_v, exp_v);
    chk("fifo_rd_en", s_rd, exp_rd);
    if (s_pop && exp_q.size() > 0) chk("m_data_order", s_d, exp_q[0]);
    if (stall_prev) begin
      chk("stall_valid_held", s_v, 1'b1);
      chk("stall_data_held", s_d, prev_d);
    end
    chk("beat_count", s_bc, exp_bc());
    if (after_reset) chk("reset_m_data", s_d, 32'd0);
    @(posedge wr_clk);
    #1;
    if (!rst_v) begin
      exp_q.delete();
      last_rd = 1'b0;
      exp_beats = 0;
      stall_prev = 1'b0;
      after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      if (s_pop && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        exp_beats++;
      end
      if (s_rd && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        fifo_dout = w;
        exp_q.push_back(w);
      end
      last_rd = s_rd;
      stall_prev = s_v && !rdy_v;
      prev_d = s_d;
      chk("outstanding_le_2", exp_q.size() <= 2, 1'b1);
    end
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    fifo_q.delete();
    fifo_empty = 1'b1;
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int          n, first_cyc, last_cyc, rd_cnt;
    bit          found;
    logic [31:0] head;
    logic [31:0] got [$];

    rst_n = 1'b0;
    m_ready = 1'b0;
    fifo_rd_rst_busy = 1'b0;
    fifo_dout = '0;
    fifo_empty = 1'b1;
    @(posedge wr_clk);
    #1;
    after_reset = 1'b1;

    // Reset hold, first-word latency, fill, release and busy suppression.
    //            rst   rdy   busy  rd    valid
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    load(8, 32'h100);
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].rst, vecs[i].rdy, vecs[i].busy);
      chk($sformatf("vec%0d_rd_en", i), s_rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_valid", i), s_v, vecs[i].exp_v);
      if (!vecs[i].rst) chk($sformatf("vec%0d_beat_count", i), s_bc, 32'd0);
    end
    $display("phase vectors: applied=16");

    // Streaming with ready held high.
    do_reset(2);
    load(16, 32'h0);
    got.delete();
    first_cyc = -1;
    last_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (s_pop) begin
        got.push_back(s_d);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    chk("stream_beats", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) chk($sformatf("stream_word%0d", i), got[i], 32'(i));
    chk("stream_consecutive", last_cyc - first_cyc, 15);
`ifdef XPMWRAP_FIFO_READER_BEAT_COUNT_EN
    chk("stream_beat_count", beat_count, 32'd16);
`else
    chk("stream_beat_count", beat_count, 32'd0);
`endif
    $display("phase stream: beats=%0d", got.size());

    // Random backpressure (and occasional busy) over 1000 words.
    do_reset(2);
    load(1000, 32'h1000_0000);
    n = 0;
    for (int c = 0; c < 8000 && n < 1000; c++) begin
      cycle(1'b1, 1'($urandom % 2), 1'(($urandom % 16) == 0));
      if (s_pop) begin
        chk("bp_word", s_d, 32'h1000_0000 + 32'(n));
        n++;
      end
    end
    chk("bp_all_words", n, 1000);
    $display("phase backpressure: beats=%0d", n);

    // Stall from empty buffer for 10 cycles, then release.
    do_reset(2);
    load(30, 32'h2000);
    rd_cnt = 0;
    repeat (10) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (s_rd) rd_cnt++;
    end
    chk("stall_rd_pulses", rd_cnt, 2);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      chk($sformatf("release_pop%0d", i), s_pop, 1'b1);
      if (i == 0) chk("release_rd_same_cycle", s_rd, 1'b1);
    end
    $display("phase stall_release: stall_reads=%0d", rd_cnt);

    // FIFO read reset busy right after a read.
    do_reset(2);
    load(4, 32'h3000);
    cycle(1'b1, 1'b0, 1'b0);
    chk("busy_first_rd", s_rd, 1'b1);
    rd_cnt = 0;
    repeat (5) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (s_rd) rd_cnt++;
    end
    chk("busy_no_rd", rd_cnt, 0);
    chk("busy_inflight_valid", m_valid, 1'b1);
    chk("busy_inflight_data", m_data, 32'h3000);
    repeat (8) cycle(1'b1, 1'b1, 1'b0);
    $display("phase rd_rst_busy: reads_during_busy=%0d", rd_cnt);

    // Reset with a full buffer.
    do_reset(2);
    load(12, 32'h4000);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    chk("midrst_full_valid", m_valid, 1'b1);
    head = fifo_q[0];
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("midrst_valid_low", s_v, 1'b0);
    chk("midrst_beat_count", s_bc, 32'd0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (s_pop) begin
        found = 1'b1;
        chk("midrst_head_word", s_d, head);
      end
    end
    chk("midrst_beat_seen", found, 1'b1);
    $display("phase midstream_reset: head=%0h", head);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xpmwrap_fifo_reader.md
# xpmwrap_fifo_reader

Read-side companion to the team's synchronous FIFO wrapper. It drives `rd_en` of a standard-mode FIFO, where data arrives on `dout` one cycle after `rd_en`. It re-times that data onto a valid/ready stream master, using a 2-entry output buffer so that full throughput is kept under arbitrary backpressure. It sits between any `xpmwrap_fifo_sync` instance (READ_MODE_FWFT=0) and a downstream streaming consumer in the same clock domain.

## Interface
- `DATA_WIDTH`, default 32: width of FIFO `dout` and `m_data`.
- `COUNT_WIDTH`, default 32: width of `beat_count`.

Ports:
- `wr_clk` in, 1: the single clock, shared with the FIFO. It is named as in the codebase.
- `rst_n` in, 1: synchronous, active-low reset.
- `fifo_dout` in, DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_empty` in, 1: FIFO empty flag.
- `fifo_rd_rst_busy` in, 1: FIFO read-domain reset in progress.
- `fifo_rd_en` out, 1: FIFO read enable. It is combinational from registered state plus `fifo_empty` and `fifo_rd_rst_busy`.
- `m_data` out, DATA_WIDTH: stream data.
- `m_valid` out, 1: stream valid.
- `m_ready` in, 1: stream ready.
- `beat_count` out, COUNT_WIDTH: count of accepted stream beats. It is only active with the macro defined; see Configuration.

## Operation
State:
- `inflight` (1 bit): `fifo_rd_en` was high last cycle.
- `occ` (0..2): buffer occupancy.
- 2-entry buffer with 1-bit write and read pointers.

`pop` = `m_valid & m_ready`.

Issue rule:
- `fifo_rd_en` = `rst_n & !fifo_empty & !fifo_rd_rst_busy & (occ + inflight - pop <= 1)`.
- Invariant: `occ + inflight <= 2` at all times. The buffer therefore never overflows and no captured word is ever dropped.

Capture rule:
- When `inflight` is 1, `fifo_dout` is written at the write pointer and the write pointer toggles.
- Capture and pop in the same cycle leave `occ` unchanged.

Output rule:
- `m_valid` = `(occ != 0)`.
- `m_data` = entry at the read pointer; it is registered storage, not a passthrough of `fifo_dout`.
- Once `m_valid` is high, `m_valid` and `m_data` are held until `pop`.

Ordering: strict FIFO order. No reordering, duplication or loss.

Reset while `rst_n` is low, applied at the clock edge:
- `occ`=0, `inflight`=0, both pointers=0, buffer contents=0.
- Outputs: `m_valid`=0, `m_data`=0, `fifo_rd_en`=0, `beat_count`=0.
- Reset mid-operation discards buffered and in-flight words. The FIFO is reset by the same source in the system, so no resynchronisation is attempted.

`fifo_rd_rst_busy` high:
- `fifo_rd_en` is suppressed.
- An already in-flight word is still captured.
- Buffered words still drain normally.

`m_ready` high while `m_valid` is low: no effect.

## Timing
- First-word latency: `fifo_empty` low in cycle 0 with `occ`=0 gives `fifo_rd_en`=1 in cycle 0, capture at the end of cycle 1, and `m_valid`=1 in cycle 2.
- Steady state: with `m_ready` held at 1 and the FIFO non-empty, one beat is output every cycle and `fifo_rd_en` stays high continuously.
- Backpressure: `m_ready` low stalls `fifo_rd_en` within the same cycle, once `occ + inflight` reaches 2. The buffer fills to 2 and no FIFO word is read that cannot be stored.
- Release: after `m_ready` rises with `occ`=2, beats are output on consecutive cycles. `fifo_rd_en` reasserts in the same cycle as the first pop, so the stream runs without a bubble.
- FIFO goes empty with `occ`=0: `m_valid` drops the cycle after the last pop.
- No combinational path from `m_ready` to `m_valid` or `m_data`. `m_ready` reaches `fifo_rd_en` combinationally.

## Configuration
Macro: `XPMWRAP_FIFO_READER_BEAT_COUNT_EN`.
- Defined:
  - `beat_count` increments by 1 on every `pop`.
  - It wraps modulo 2^COUNT_WIDTH.
  - It is cleared only by reset.
- Undefined: `beat_count` is tied to 0 and no counter logic is built.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0 for 3 cycles with `fifo_empty`=0.
  - Required: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0 and `beat_count`=0 throughout.
  - Required: first `fifo_rd_en` in the cycle after release, first `m_valid` 2 cycles later.
- Streaming:
  - Stimulus: FIFO preloaded with 0x00..0x0F, `m_ready`=1.
  - Required: 16 beats on consecutive cycles, in order.
  - Required: `beat_count`=16 with the macro defined, 0 without it.
- Backpressure:
  - Stimulus: random `m_ready` (50%) over 1000 words.
  - Required: every word output exactly once, in order.
  - Required: `m_data` stable while stalled; `occ+inflight` never exceeds 2.
- Stall and release:
  - Stimulus: `m_ready`=0 for 10 cycles, then 1.
  - Required: exactly 2 `fifo_rd_en` pulses during the stall.
  - Required: after release, beats on consecutive cycles with no bubble.
- FIFO reset busy:
  - Stimulus: assert `fifo_rd_rst_busy` in the cycle after a `fifo_rd_en`.
  - Required: that in-flight word is still output; no further `fifo_rd_en` until busy clears.
- Mid-stream reset:
  - Stimulus: `rst_n`=0 for 1 cycle with `occ`=2.
  - Required: `m_valid`=0 on the next cycle, `beat_count`=0, and the next beat after recovery is the FIFO's new head word.
